conseq00_frame_tx: RTL and testbench

Serial frame transmitter that drives the single-bit `x` line consumed by our consecutive-00 / parity detector FSMs. It accepts a parallel word through a valid/ready handshake and emits it MSB-first, one bit per clock. The frame carries a start marker, a bit-stuffed payload and an odd-parity bit, and ends with the "00" terminator. Stuffing guarantees that "00" never appears inside a frame, so the receiving detector sees "00" only at the frame end.

---
 rtl/conseq00_frame_tx_if.sv | 30 +++
 rtl/conseq00_frame_tx.sv | 146 ++++++++++++++
 tb/tb_conseq00_frame_tx.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conseq00_frame_tx_if.sv
// Parallel-in / serial-out link between a word source and conseq00_frame_tx.
// The slave side is the transmitter; the master side is the word source and line observer.
interface conseq00_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic              tx_bit;
    logic              tx_active;
    logic              tx_done;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  tx_bit,
        input  tx_active,
        input  tx_done
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output tx_bit,
        output tx_active,
        output tx_done
    );
endinterface

// File: rtl/conseq00_frame_tx.sv
// Bit-stuffed serial frame transmitter: START, stuffed MSB-first payload, odd parity, "00" end.
// START hits the line the cycle after accept; din_ready is high only in IDLE, words offered while busy wait.
module conseq00_frame_tx #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    conseq00_frame_tx_if.slave  bus
);
    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STUFF  = 3'd3;
    localparam logic [2:0] S_PARITY = 3'd4;
    localparam logic [2:0] S_END0   = 3'd5;
    localparam logic [2:0] S_END1   = 3'd6;

    localparam logic [1:0] R_DATA   = 2'd0;
    localparam logic [1:0] R_PARITY = 2'd1;
    localparam logic [1:0] R_END0   = 2'd2;

    // state always names the frame element currently on tx_bit
    logic [2:0]        state, nxt_state;
    logic [1:0]        ret, nxt_ret;
    logic [DATA_W-1:0] sh, nxt_sh;
    logic [CNT_W-1:0]  cnt, nxt_cnt;
    logic              par, nxt_par;
    logic              bit_q, nxt_bit;
    logic              done_q, nxt_done;
    logic              accept;
    logic              more_bits;

    assign accept    = (state == S_IDLE) && bus.din_valid;
    assign more_bits = (cnt != LAST_IDX);

    always_comb begin
        nxt_state = state;
        nxt_ret   = ret;
        nxt_sh    = sh;
        nxt_cnt   = cnt;
        nxt_par   = par;
        nxt_bit   = 1'b1;
        nxt_done  = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    nxt_state = S_START;
                    nxt_bit   = 1'b0;
                    nxt_sh    = bus.din;
                    nxt_cnt   = '0;
                    nxt_par   = ~^bus.din;
                end
            end
            S_START: begin
                nxt_state = S_STUFF;
                nxt_ret   = R_DATA;
                nxt_bit   = 1'b1;
            end
            S_DATA: begin
                if (more_bits) begin
                    nxt_cnt = cnt + 1'b1;
                end
                if (!bit_q) begin
                    nxt_state = S_STUFF;
                    nxt_ret   = more_bits ? R_DATA : R_PARITY;
                    nxt_bit   = 1'b1;
                end else if (more_bits) begin
                    nxt_state = S_DATA;
                    nxt_bit   = sh[DATA_W-1];
                    nxt_sh    = {sh[DATA_W-2:0], 1'b0};
                end else begin
                    nxt_state = S_PARITY;
                    nxt_bit   = par;
                end
            end
            S_STUFF: begin
                case (ret)
                    R_DATA: begin
                        nxt_state = S_DATA;
                        nxt_bit   = sh[DATA_W-1];
                        nxt_sh    = {sh[DATA_W-2:0], 1'b0};
                    end
                    R_PARITY: begin
                        nxt_state = S_PARITY;
                        nxt_bit   = par;
                    end
                    default: begin
                        nxt_state = S_END0;
                        nxt_bit   = 1'b0;
                    end
                endcase
            end
            S_PARITY: begin
                if (!bit_q) begin
                    nxt_state = S_STUFF;
                    nxt_ret   = R_END0;
                    nxt_bit   = 1'b1;
                end else begin
                    nxt_state = S_END0;
                    nxt_bit   = 1'b0;
                end
            end
            S_END0: begin
                nxt_state = S_END1;
                nxt_bit   = 1'b0;
                nxt_done  = 1'b1;
            end
            S_END1: begin
                nxt_state = S_IDLE;
                nxt_bit   = 1'b1;
            end
            default: begin
                nxt_state = S_IDLE;
                nxt_bit   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            ret    <= R_DATA;
            sh     <= '0;
            cnt    <= '0;
            par    <= 1'b0;
            bit_q  <= 1'b1;
            done_q <= 1'b0;
        end else begin
            state  <= nxt_state;
            ret    <= nxt_ret;
            sh     <= nxt_sh;
            cnt    <= nxt_cnt;
            par    <= nxt_par;
            bit_q  <= nxt_bit;
            done_q <= nxt_done;
        end
    end

    assign bus.din_ready = (state == S_IDLE);
    assign bus.tx_bit    = bit_q;
    assign bus.tx_active = (state != S_IDLE);
    assign bus.tx_done   = done_q;
endmodule

// File: tb/tb_conseq00_frame_tx.sv
// Randomized and directed bench for conseq00_frame_tx against a frame-building reference model.
module tb_conseq00_frame_tx;
    logic clk;
    logic reset_n;

    conseq00_frame_tx_if #(.DATA_W(8)) bus ();

    conseq00_frame_tx #(.DATA_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit exp_q[$];
    bit obs_q[$];
    int done_idx;
    int done_cnt;
    int ready_cnt;
    bit timed_out;

    // Expected line bits for one frame, built straight from the framing rules
    task automatic model_frame(input logic [7:0] w);
        bit p;
        exp_q.delete();
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        for (int i = 7; i >= 0; i--) begin
            exp_q.push_back(w[i]);
            if (!w[i]) exp_q.push_back(1'b1);
        end
        p = ($countones(w) % 2 == 0);
        exp_q.push_back(p);
        if (!p) exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
    endtask

    function automatic int frame_len(input logic [7:0] w);
        int z;
        int p;
        z = 8 - $countones(w);
        p = ($countones(w) % 2 == 0) ? 1 : 0;
        return 2 + 8 + z + 1 + (1 - p) + 2;
    endfunction

    // Offers w and returns #1 after the accepting edge
    task automatic accept(input logic [7:0] w, input bit hold);
        int n;
        bus.din = w;
        bus.din_valid = 1'b1;
        n = 0;
        while (!bus.din_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (bus.din_ready !== 1'b1 || bus.tx_bit !== 1'b1) begin
            errors++;
            $display("FAIL accept_idle: din_ready=%b tx_bit=%b, required 1 and 1", bus.din_ready, bus.tx_bit);
        end
        @(posedge clk); #1;
        if (!hold) bus.din_valid = 1'b0;
    endtask

    task automatic capture();
        int n;
        obs_q.delete();
        done_idx = -1;
        done_cnt = 0;
        ready_cnt = 0;
        n = 0;
        while (bus.tx_active && n < 200) begin
            obs_q.push_back(bus.tx_bit);
            if (bus.tx_done) begin
                done_idx = obs_q.size() - 1;
                done_cnt++;
            end
            if (bus.din_ready) ready_cnt++;
            @(posedge clk); #1;
            n++;
        end
        timed_out = bus.tx_active;
    endtask

    task automatic test_frame(input logic [7:0] w);
        int bad;
        accept(w, 1'b0);
        capture();
        model_frame(w);
        checks++;
        if (timed_out) begin
            errors++;
            $display("FAIL frame_timeout %h: tx_active still 1 after 200 cycles, required frame end", w);
        end
        checks++;
        if (obs_q.size() != exp_q.size() || obs_q.size() != frame_len(w)) begin
            errors++;
            $display("FAIL frame_len %h: got %0d bits, required %0d", w, obs_q.size(), frame_len(w));
        end
        bad = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (bad < 0 && (i >= obs_q.size() || obs_q[i] !== exp_q[i])) bad = i;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL frame_bits %h: first difference at bit %0d, got %b required %b", w, bad,
                     (bad < obs_q.size()) ? obs_q[bad] : 1'bx, exp_q[bad]);
        end
        checks++;
        if (done_cnt != 1 || done_idx != exp_q.size() - 1) begin
            errors++;
            $display("FAIL frame_done %h: %0d pulses at bit %0d, required 1 pulse at bit %0d", w, done_cnt, done_idx, exp_q.size() - 1);
        end
        checks++;
        if (ready_cnt != 0) begin
            errors++;
            $display("FAIL frame_busy_ready %h: din_ready high %0d cycles in frame, required 0", w, ready_cnt);
        end
        checks++;
        if (bus.tx_bit !== 1'b1 || bus.tx_active !== 1'b0 || bus.din_ready !== 1'b1 || bus.tx_done !== 1'b0) begin
            errors++;
            $display("FAIL frame_after %h: bit=%b active=%b ready=%b done=%b, required 1 0 1 0", w,
                     bus.tx_bit, bus.tx_active, bus.din_ready, bus.tx_done);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.din = '0;
        bus.din_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.tx_bit !== 1'b1 || bus.tx_active !== 1'b0 || bus.tx_done !== 1'b0 || bus.din_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: bit=%b active=%b done=%b ready=%b, required 1 0 0 1",
                     bus.tx_bit, bus.tx_active, bus.tx_done, bus.din_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.tx_bit !== 1'b1 || bus.tx_active !== 1'b0 || bus.din_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_idle: bit=%b active=%b ready=%b, required 1 0 1",
                     bus.tx_bit, bus.tx_active, bus.din_ready);
        end
    endtask

    task automatic test_directed();
        logic [7:0]  words [4];
        int          lens  [4];
        logic [16:0] a5_ref;
        int          bad;
        words = '{8'hFF, 8'h00, 8'hA5, 8'h01};
        lens  = '{13, 21, 17, 21};
        a5_ref = 17'b0_1_1_0_1_1_0_1_0_1_1_0_1_1_1_0_0;
        for (int k = 0; k < 4; k++) begin
            test_frame(words[k]);
            checks++;
            if (obs_q.size() != lens[k]) begin
                errors++;
                $display("FAIL directed_len %h: got %0d bits, required %0d", words[k], obs_q.size(), lens[k]);
            end
            if (words[k] == 8'hA5) begin
                bad = -1;
                for (int i = 0; i < 17; i++)
                    if (bad < 0 && (i >= obs_q.size() || obs_q[i] !== a5_ref[16-i])) bad = i;
                checks++;
                if (bad >= 0) begin
                    errors++;
                    $display("FAIL directed_a5_stream: first difference at bit %0d, required %b", bad, a5_ref[16-bad]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 25; k++) begin
            test_frame(8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        bit q1[$];
        bit q2[$];
        bit all[$];
        int pairs;
        int r1;
        int bad;
        accept(8'hFF, 1'b1);
        bus.din = 8'h00;
        capture();
        q1 = obs_q;
        r1 = ready_cnt;
        checks++;
        if (r1 != 0) begin
            errors++;
            $display("FAIL b2b_ready_first: din_ready high %0d cycles in first frame, required 0", r1);
        end
        checks++;
        if (bus.tx_bit !== 1'b1 || bus.din_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap: bit=%b ready=%b, required 1 1", bus.tx_bit, bus.din_ready);
        end
        @(posedge clk); #1;
        bus.din_valid = 1'b0;
        capture();
        q2 = obs_q;
        model_frame(8'hFF);
        bad = (q1 == exp_q) ? 0 : 1;
        model_frame(8'h00);
        if (q2 != exp_q) bad += 2;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL b2b_frames: wrong frame(s) code %0d (1=first 2=second), lengths %0d %0d required 13 21",
                     bad, q1.size(), q2.size());
        end
        all = q1;
        all.push_back(1'b1);
        foreach (q2[i]) all.push_back(q2[i]);
        pairs = 0;
        for (int i = 0; i + 1 < all.size(); i++)
            if (all[i] == 1'b0 && all[i+1] == 1'b0 && i != q1.size() - 2 && i != all.size() - 2) pairs++;
        checks++;
        if (pairs != 0) begin
            errors++;
            $display("FAIL b2b_no_inner_00: found %0d inner 00 pairs, required 0", pairs);
        end
    endtask

    task automatic test_reset_mid();
        int done_seen;
        accept(8'h5A, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        done_seen = bus.tx_done ? 1 : 0;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.tx_bit !== 1'b1 || bus.tx_active !== 1'b0 || bus.din_ready !== 1'b1 || bus.tx_done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: bit=%b active=%b ready=%b done=%b, required 1 0 1 0",
                     bus.tx_bit, bus.tx_active, bus.din_ready, bus.tx_done);
        end
        repeat (2) begin
            @(posedge clk); #1;
            if (bus.tx_done) done_seen++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.tx_done) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL midreset_no_done: tx_done seen %0d times, required 0", done_seen);
        end
        test_frame(8'h3C);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
